// File: rtl/spart_rx.sv
// SPART receiver: oversampled 8N1 deserializer with start-bit glitch rejection,
// break handling, and a single-entry holding register with overrun reporting.
module spart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int MID_SAMPLE = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_enable,
    input  logic       rxd,
    input  logic       read,
    output logic [7:0] rx_data,
    output logic       rda,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID_SAMPLE);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       idx, idx_next;
    logic [7:0]       shift, shift_next;
    logic             frame_done;
    logic             rx_meta, rxs;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            shift <= shift_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shift_next = shift;
        frame_done = 1'b0;
        if (rx_enable) begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state_next = START;
                        cnt_next   = '0;
                    end
                end
                START: begin
                    // A line that is high again at mid start bit was only a glitch.
                    if (cnt == CNT_MID) begin
                        cnt_next   = '0;
                        idx_next   = '0;
                        state_next = rxs ? IDLE : DATA;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt_next        = '0;
                        shift_next[idx] = rxs;
                        if (idx == 3'd7) begin
                            state_next = STOP;
                        end else begin
                            idx_next = idx + 3'd1;
                        end
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt_next   = '0;
                        frame_done = 1'b1;
                        state_next = rxs ? IDLE : WAIT_HIGH;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Holding register: a read in the completion cycle frees the slot for the new byte.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_data   <= 8'h00;
            rda       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (frame_done) begin
            if (!rda || read) begin
                rx_data   <= shift;
                rda       <= 1'b1;
                frame_err <= ~rxs;
                overrun   <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (read && rda) begin
            rda     <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule
